// File: rtl/wb_req_queue.sv
// wb_req_queue: request FIFO feeding the Wishbone master one transaction at a time,
// returning a single-cycle response pulse per completed transfer.
module wb_req_queue #(
   parameter int DATA_WL = 16,
   parameter int ADR_WL  = 16,
   parameter int DEPTH   = 4,
   parameter int PTR_WL  = 2
) (
   input  logic               clk,
   input  logic               a_reset_l,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic               req_we_i,
   input  logic [ADR_WL-1:0]  req_addr_i,
   input  logic [DATA_WL-1:0] req_data_i,
   input  logic               flush_i,
   output logic               rsp_valid_o,
   output logic               rsp_we_o,
   output logic [DATA_WL-1:0] rsp_data_o,
   output logic [PTR_WL:0]    count_o,
   output logic               mem_start_o,
   output logic               mem_we_o,
   output logic [ADR_WL-1:0]  mem_addr_o,
   output logic [DATA_WL-1:0] mem_data_o,
   input  logic               mem_busy_i,
   input  logic               mem_valid_i,
   input  logic [DATA_WL-1:0] mem_data_i
);
   typedef enum logic [3:0] {
      IDLE      = 4'b0001,
      ISSUE     = 4'b0010,
      WAIT_ACC  = 4'b0100,
      WAIT_DONE = 4'b1000
   } state_t;
   localparam logic [PTR_WL:0] FULL = (PTR_WL+1)'(DEPTH);
   logic [ADR_WL+DATA_WL:0] r_mem [DEPTH];
   logic [PTR_WL-1:0]       r_wptr, r_rptr;
   logic [PTR_WL:0]         r_count;
   state_t                  r_state;
   logic                    w_push, w_pop;
   logic [ADR_WL+DATA_WL:0] w_head;
   assign req_ready_o = r_count != FULL;
   assign count_o     = r_count;
   assign w_push      = req_valid_i && req_ready_o && !flush_i;
   assign w_pop       = r_state == IDLE && r_count != '0 && !flush_i;
   assign w_head      = r_mem[r_rptr];
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wptr] <= {req_we_i, req_addr_i, req_data_i};
   always_ff @(posedge clk or negedge a_reset_l)
      if (!a_reset_l) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_WL'(1);
         if (w_pop) r_rptr <= r_rptr + PTR_WL'(1);
         r_count <= r_count + (PTR_WL+1)'(w_push) - (PTR_WL+1)'(w_pop);
      end
   // The in-flight transfer lives only in the mem_* registers, so flush never touches it.
   always_ff @(posedge clk or negedge a_reset_l)
      if (!a_reset_l) begin
         r_state     <= IDLE;
         mem_start_o <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_data_o  <= '0;
         rsp_valid_o <= 1'b0;
         rsp_we_o    <= 1'b0;
         rsp_data_o  <= '0;
      end else begin
         rsp_valid_o <= 1'b0;
         case (r_state)
            IDLE:
               if (w_pop) begin
                  {mem_we_o, mem_addr_o, mem_data_o} <= w_head;
                  mem_start_o <= 1'b1;
                  r_state     <= ISSUE;
               end
            ISSUE: begin
               mem_start_o <= 1'b0;
               r_state     <= WAIT_ACC;
            end
            WAIT_ACC:
               if (mem_busy_i) r_state <= WAIT_DONE;
            WAIT_DONE:
               if (mem_valid_i) begin
                  rsp_data_o  <= mem_data_i;
                  rsp_we_o    <= mem_we_o;
                  rsp_valid_o <= 1'b1;
                  r_state     <= IDLE;
               end
            default: begin
               mem_start_o <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
endmodule

// File: tb/tb_wb_req_queue.sv
// tb_wb_req_queue: directed and random stimulus for wb_req_queue, checked every cycle
// against a transaction-level queue model and a behavioural master/slave.
module tb_wb_req_queue;
   localparam int DW = 16, AW = 16, DEPTH = 4, PW = 2;
   typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] data;} req_t;
   logic clk = 1'b0, a_reset_l = 1'b1;
   logic req_valid_i, req_ready_o, req_we_i, flush_i;
   logic [AW-1:0] req_addr_i, mem_addr_o;
   logic [DW-1:0] req_data_i, rsp_data_o, mem_data_o, mem_data_i;
   logic rsp_valid_o, rsp_we_o, mem_start_o, mem_we_o, mem_busy_i, mem_valid_i;
   logic [PW:0] count_o;
   always #5 clk = ~clk;
   wb_req_queue #(.DATA_WL(DW), .ADR_WL(AW), .DEPTH(DEPTH), .PTR_WL(PW)) dut (
      .clk(clk), .a_reset_l(a_reset_l),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_data_i(req_data_i), .flush_i(flush_i),
      .rsp_valid_o(rsp_valid_o), .rsp_we_o(rsp_we_o), .rsp_data_o(rsp_data_o),
      .count_o(count_o), .mem_start_o(mem_start_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_busy_i(mem_busy_i),
      .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i));
   int n_tests = 0, n_fail = 0;
   req_t q[$];
   req_t last;
   logic outst, acc, last_push, rsp_we_m;
   logic [DW-1:0] rsp_data_m;
   int n, n_rsp_m, n_rsp_dut, n_start_dut;
   int sl_act, sl_cnt, sl_d1, sl_d2, stall_len, stale_mode, force_en, d1_fix;
   logic [DW-1:0] force_val;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask
   task automatic reset_model();
      q.delete();
      last = '0; outst = 0; acc = 0; n = 0; rsp_we_m = 0; rsp_data_m = '0; sl_act = 0;
   endtask
   task automatic check_reset();
      chk("rst_ready", req_ready_o, 1);
      chk("rst_count", count_o, 0);
      chk("rst_start", mem_start_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_rsp_we", rsp_we_o, 0);
      chk("rst_rsp_data", rsp_data_o, 0);
      chk("rst_mem_we", mem_we_o, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_mem_data", mem_data_o, 0);
   endtask
   // One clock: predict from pre-edge inputs, advance, compare, then let the slave react.
   task automatic cyc();
      logic pf, pb, pvl, es, er, na, pp;
      logic [DW-1:0] pd;
      req_t nr;
      pf = flush_i; pb = mem_busy_i; pvl = mem_valid_i; pd = mem_data_i;
      nr = {req_we_i, req_addr_i, req_data_i};
      es = !outst && q.size() != 0 && !pf;
      pp = req_valid_i && q.size() < DEPTH && !pf;
      er = outst && acc && pvl;
      na = outst && !acc && n >= 1 && pb;
      @(posedge clk); #1;
      if (er) begin outst = 0; rsp_we_m = last.we; rsp_data_m = pd; n_rsp_m++; end
      if (na) acc = 1;
      if (outst) n++;
      if (pf) q.delete();
      if (es) begin last = q.pop_front(); outst = 1; acc = 0; n = 0; end
      if (pp) q.push_back(nr);
      last_push = pp;
      if (rsp_valid_o) n_rsp_dut++;
      if (mem_start_o) n_start_dut++;
      chk("ready", req_ready_o, q.size() < DEPTH);
      chk("count", count_o, q.size());
      chk("mem_start", mem_start_o, es);
      chk("rsp_valid", rsp_valid_o, er);
      chk("rsp_we", rsp_we_o, rsp_we_m);
      chk("rsp_data", rsp_data_o, rsp_data_m);
      chk("mem_we", mem_we_o, last.we);
      chk("mem_addr", mem_addr_o, last.addr);
      chk("mem_data", mem_data_o, last.data);
      if (es) begin
         sl_act = 1; sl_cnt = 0;
         sl_d1 = d1_fix >= 0 ? d1_fix : int'($urandom_range(0, 2));
         sl_d2 = stall_len != 0 ? stall_len : int'($urandom_range(2, 4));
         if (stale_mode == 0) mem_valid_i = 1'b0;
      end
      if (sl_act != 0) begin
         if (sl_cnt >= sl_d1 + sl_d2) begin
            mem_busy_i = 1'b0; mem_valid_i = 1'b1; sl_act = 0;
            mem_data_i = force_en != 0 ? force_val : 16'($urandom);
         end else if (sl_cnt >= sl_d1) begin
            mem_busy_i = 1'b1; mem_valid_i = 1'b0;
         end
         sl_cnt++;
      end
   endtask
   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cyc();
   endtask
   task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid_i = 1'b1; req_we_i = we; req_addr_i = a; req_data_i = d;
      for (int i = 0; i < 100; i++) begin
         cyc();
         if (last_push) break;
      end
      chk("push_accept", last_push, 1);
      req_valid_i = 1'b0;
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end
   initial begin
      req_valid_i = 0; req_we_i = 0; req_addr_i = '0; req_data_i = '0; flush_i = 0;
      mem_busy_i = 0; mem_valid_i = 0; mem_data_i = '0;
      stall_len = 0; stale_mode = 0; force_en = 0; force_val = '0; d1_fix = -1;
      n_rsp_m = 0; n_rsp_dut = 0; n_start_dut = 0; last_push = 0;
      reset_model();
      #2 a_reset_l = 1'b0;
      #1 check_reset();
      repeat (2) @(posedge clk);
      #1 a_reset_l = 1'b1;
      // single write
      n_rsp_dut = 0;
      push(1'b1, 16'h0010, 16'hBEEF);
      idle(20);
      chk("t1_rsp_count", n_rsp_dut, 1);
      chk("t1_rsp_we", rsp_we_o, 1);
      // single read with fixed slave data; value must persist
      force_en = 1; force_val = 16'h1234; n_rsp_dut = 0;
      push(1'b0, 16'h0020, 16'h0000);
      idle(20);
      chk("t2_rsp_count", n_rsp_dut, 1);
      chk("t2_rsp_data", rsp_data_o, 16'h1234);
      chk("t2_rsp_we", rsp_we_o, 0);
      force_en = 0;
      // stalled slave fills the queue
      stall_len = 30; n_rsp_dut = 0;
      for (int i = 0; i < 5; i++) push(i[0], 16'(16'h0100 + i), 16'($urandom));
      chk("t3_full_count", count_o, DEPTH);
      chk("t3_full_ready", req_ready_o, 0);
      stall_len = 0;
      push(1'b0, 16'h0200, 16'h0);
      idle(80);
      chk("t3_rsp_count", n_rsp_dut, 6);
      // flush with one request in flight
      stall_len = 10; n_rsp_dut = 0; n_start_dut = 0;
      for (int i = 0; i < 3; i++) push(1'b1, 16'(16'h0300 + i), 16'($urandom));
      flush_i = 1'b1;
      cyc();
      flush_i = 1'b0;
      chk("t4_flush_count", count_o, 0);
      stall_len = 0;
      idle(40);
      chk("t4_rsp_count", n_rsp_dut, 1);
      chk("t4_start_count", n_start_dut, 1);
      // stale valid from the previous transfer held through ISSUE and WAIT_ACC
      stale_mode = 1; d1_fix = 2; n_rsp_dut = 0;
      chk("t5_stale_valid", mem_valid_i, 1);
      push(1'b1, 16'h0400, 16'h5A5A);
      idle(20);
      chk("t5_rsp_count", n_rsp_dut, 1);
      stale_mode = 0; d1_fix = -1;
      // asynchronous reset while waiting for completion
      stall_len = 20;
      push(1'b0, 16'h0500, 16'h0);
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (acc) break;
      end
      chk("t6_reach_wait_done", acc, 1);
      #2 a_reset_l = 1'b0;
      #1 check_reset();
      reset_model();
      mem_busy_i = 1'b0; mem_valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 a_reset_l = 1'b1;
      stall_len = 0; n_rsp_dut = 0;
      idle(30);
      chk("t6_no_rsp", n_rsp_dut, 0);
      // random traffic with occasional flushes and stale completions
      n_rsp_dut = 0; n_rsp_m = 0;
      for (int i = 0; i < 3000; i++) begin
         req_valid_i = 1'($urandom); req_we_i = 1'($urandom);
         req_addr_i = 16'($urandom); req_data_i = 16'($urandom);
         flush_i = ($urandom_range(0, 49) == 0);
         stale_mode = int'($urandom_range(0, 1));
         cyc();
      end
      req_valid_i = 1'b0; flush_i = 1'b0;
      idle(40);
      chk("rand_drain_count", count_o, 0);
      chk("rand_rsp_total", n_rsp_dut, n_rsp_m);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
